// File: rtl/injection_module_core.sv
// Two-stage registered logic cone (n1/n2/n3 -> y1/y2) with a parameter-driven
// stuck-at injector that forces one register during a counter-defined window.
module injection_module_core #(
    parameter int FAULT_EN    = 0,
    parameter int FAULT_NODE  = 0,
    parameter int FAULT_VAL   = 0,
    parameter int FAULT_START = 4,
    parameter int FAULT_LEN   = 4,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    input  logic f,
    output logic y1,
    output logic y2
);

    // Window bounds carry one extra bit so START+LEN cannot wrap.
    localparam logic [CNT_W:0]   WIN_LO    = (CNT_W+1)'(FAULT_START);
    localparam logic [CNT_W:0]   WIN_HI    = WIN_LO + (CNT_W+1)'(FAULT_LEN);
    localparam logic             INJ_ON    = (FAULT_EN != 0) && (FAULT_LEN != 0);
    localparam logic [2:0]       NODE_SEL  = 3'(FAULT_NODE);
    localparam logic             FORCE_VAL = 1'(FAULT_VAL);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic             n1_q, n2_q, n3_q, y1_q, y2_q;
    logic             n1_d, n2_d, n3_d, y1_d, y2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             win_s;
    logic [4:0]       force_s;

    // Fault window decode and one-hot selection of the forced register.
    always_comb begin
        win_s   = 1'b0;
        force_s = 5'b00000;
        if (INJ_ON && ({1'b0, cnt_q} >= WIN_LO) && ({1'b0, cnt_q} < WIN_HI)) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        if (win_s) begin
            case (NODE_SEL)
                3'd0:    force_s = 5'b00001;
                3'd1:    force_s = 5'b00010;
                3'd2:    force_s = 5'b00100;
                3'd3:    force_s = 5'b01000;
                3'd4:    force_s = 5'b10000;
                default: force_s = 5'b00000;
            endcase
        end else begin
            force_s = 5'b00000;
        end
    end

    // Next-state for both pipeline stages and the saturating counter.
    always_comb begin
        n1_d  = force_s[0] ? FORCE_VAL : (a & b);
        n2_d  = force_s[1] ? FORCE_VAL : (c ^ d);
        n3_d  = force_s[2] ? FORCE_VAL : (e | f);
        y1_d  = force_s[3] ? FORCE_VAL : (n1_q | n2_q);
        y2_d  = force_s[4] ? FORCE_VAL : (n2_q & n3_q);
        cnt_d = cnt_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset wins over any window in progress.
    always_ff @(posedge clk) begin
        if (rstn) begin
            n1_q  <= 1'b0;
            n2_q  <= 1'b0;
            n3_q  <= 1'b0;
            y1_q  <= 1'b0;
            y2_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            n1_q  <= n1_d;
            n2_q  <= n2_d;
            n3_q  <= n3_d;
            y1_q  <= y1_d;
            y2_q  <= y2_d;
            cnt_q <= cnt_d;
        end
    end

    assign y1 = y1_q;
    assign y2 = y2_q;

endmodule

// File: tb/tb_injection_module_core.sv
// Bench for injection_module_core: six parameter variants share one stimulus
// stream and are compared each cycle against a behavioural model.
module tb_injection_module_core;

    localparam int NCFG = 6;
    // 0: no injection, 1: y2 stuck-0 @4..7, 2: n2 stuck-1 @2, 3: n1 stuck-1 @0..2,
    // 4: n3 stuck-0 from 6 with 3-bit counter (never closes), 5: enabled but node 5
    localparam int C_EN    [NCFG] = '{0, 1, 1, 1, 1, 1};
    localparam int C_NODE  [NCFG] = '{0, 4, 1, 0, 2, 5};
    localparam int C_VAL   [NCFG] = '{0, 0, 1, 1, 0, 1};
    localparam int C_START [NCFG] = '{4, 4, 2, 0, 6, 0};
    localparam int C_LEN   [NCFG] = '{4, 4, 1, 3, 4, 8};
    localparam int C_CW    [NCFG] = '{16, 16, 16, 16, 3, 16};

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0, f = 1'b0;
    logic y1_s [NCFG];
    logic y2_s [NCFG];

    int n_tests = 0;
    int n_fail  = 0;

    bit m_n1 [NCFG], m_n2 [NCFG], m_n3 [NCFG], m_y1 [NCFG], m_y2 [NCFG];
    int m_t = 0;

    always #5 clk = ~clk;

    injection_module_core #(.FAULT_EN(C_EN[0]), .FAULT_NODE(C_NODE[0]), .FAULT_VAL(C_VAL[0]),
        .FAULT_START(C_START[0]), .FAULT_LEN(C_LEN[0]), .CNT_W(C_CW[0])) u_dut0 (
        .clk(clk), .rstn(rstn), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .y1(y1_s[0]), .y2(y2_s[0]));
    injection_module_core #(.FAULT_EN(C_EN[1]), .FAULT_NODE(C_NODE[1]), .FAULT_VAL(C_VAL[1]),
        .FAULT_START(C_START[1]), .FAULT_LEN(C_LEN[1]), .CNT_W(C_CW[1])) u_dut1 (
        .clk(clk), .rstn(rstn), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .y1(y1_s[1]), .y2(y2_s[1]));
    injection_module_core #(.FAULT_EN(C_EN[2]), .FAULT_NODE(C_NODE[2]), .FAULT_VAL(C_VAL[2]),
        .FAULT_START(C_START[2]), .FAULT_LEN(C_LEN[2]), .CNT_W(C_CW[2])) u_dut2 (
        .clk(clk), .rstn(rstn), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .y1(y1_s[2]), .y2(y2_s[2]));
    injection_module_core #(.FAULT_EN(C_EN[3]), .FAULT_NODE(C_NODE[3]), .FAULT_VAL(C_VAL[3]),
        .FAULT_START(C_START[3]), .FAULT_LEN(C_LEN[3]), .CNT_W(C_CW[3])) u_dut3 (
        .clk(clk), .rstn(rstn), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .y1(y1_s[3]), .y2(y2_s[3]));
    injection_module_core #(.FAULT_EN(C_EN[4]), .FAULT_NODE(C_NODE[4]), .FAULT_VAL(C_VAL[4]),
        .FAULT_START(C_START[4]), .FAULT_LEN(C_LEN[4]), .CNT_W(C_CW[4])) u_dut4 (
        .clk(clk), .rstn(rstn), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .y1(y1_s[4]), .y2(y2_s[4]));
    injection_module_core #(.FAULT_EN(C_EN[5]), .FAULT_NODE(C_NODE[5]), .FAULT_VAL(C_VAL[5]),
        .FAULT_START(C_START[5]), .FAULT_LEN(C_LEN[5]), .CNT_W(C_CW[5])) u_dut5 (
        .clk(clk), .rstn(rstn), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .y1(y1_s[5]), .y2(y2_s[5]));

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock edge of the behavioural model; m_t counts edges since release.
    task automatic model_edge();
        for (int k = 0; k < NCFG; k++) begin
            int  maxv, cnt;
            bit  win, fv, nn1, nn2, nn3, ny1, ny2;
            if (rstn) begin
                m_n1[k] = 1'b0; m_n2[k] = 1'b0; m_n3[k] = 1'b0;
                m_y1[k] = 1'b0; m_y2[k] = 1'b0;
            end else begin
                maxv = (1 << C_CW[k]) - 1;
                cnt  = (m_t > maxv) ? maxv : m_t;
                win  = (C_EN[k] != 0) && (C_LEN[k] != 0) &&
                       (cnt >= C_START[k]) && (cnt < C_START[k] + C_LEN[k]);
                fv   = (C_VAL[k] != 0);
                nn1  = (win && C_NODE[k] == 0) ? fv : (a & b);
                nn2  = (win && C_NODE[k] == 1) ? fv : (c ^ d);
                nn3  = (win && C_NODE[k] == 2) ? fv : (e | f);
                ny1  = (win && C_NODE[k] == 3) ? fv : (m_n1[k] | m_n2[k]);
                ny2  = (win && C_NODE[k] == 4) ? fv : (m_n2[k] & m_n3[k]);
                m_n1[k] = nn1; m_n2[k] = nn2; m_n3[k] = nn3;
                m_y1[k] = ny1; m_y2[k] = ny2;
            end
        end
        m_t = rstn ? 0 : m_t + 1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < NCFG; k++) begin
            chk($sformatf("model_y1_cfg%0d_t%0d", k, m_t), y1_s[k], m_y1[k]);
            chk($sformatf("model_y2_cfg%0d_t%0d", k, m_t), y2_s[k], m_y2[k]);
        end
    endtask

    task automatic set_in(input logic [5:0] v);
        {a, b, c, d, e, f} = v;
    endtask

    initial begin
        // Reset held 3 edges with all inputs high.
        rstn = 1'b1; set_in(6'b111111);
        for (int i = 0; i < 3; i++) step();
        chk("rst_y1", y1_s[0], 1'b0);
        chk("rst_y2", y2_s[0], 1'b0);
        rstn = 1'b0;
        for (int i = 0; i < 2; i++) step();
        chk("ones_y1", y1_s[0], 1'b1);
        chk("ones_y2", y2_s[0], 1'b0);

        // Latency and truth table on the fault-free variant.
        rstn = 1'b1; step(); rstn = 1'b0;
        set_in(6'b111001);
        step();
        chk("lat1_y2_not_yet", y2_s[0], 1'b0);
        step();
        chk("lat2_y1", y1_s[0], 1'b1);
        chk("lat2_y2", y2_s[0], 1'b1);
        c = 1'b0;
        step(); step();
        chk("c0_y1", y1_s[0], 1'b1);
        chk("c0_y2", y2_s[0], 1'b0);
        set_in(6'b000000);
        step(); step();
        chk("zero_y1", y1_s[0], 1'b0);
        chk("zero_y2", y2_s[0], 1'b0);
        set_in(6'b001010);
        step(); step();
        chk("ce_y1", y1_s[0], 1'b1);
        chk("ce_y2", y2_s[0], 1'b1);

        // y2 stuck-0 window: edges 5..8 after release see cnt 4..7.
        rstn = 1'b1; step(); rstn = 1'b0;
        set_in(6'b001010);
        for (int s = 1; s <= 12; s++) begin
            step();
            chk($sformatf("inj_y2_s%0d", s), y2_s[1], (s >= 2) && !(s >= 5 && s <= 8));
            chk($sformatf("inj_y1_s%0d", s), y1_s[1], s >= 2);
        end

        // n2 stuck-1 for one edge (cnt 2) shows as a single y1 pulse.
        rstn = 1'b1; step(); rstn = 1'b0;
        set_in(6'b000000);
        for (int s = 1; s <= 8; s++) begin
            step();
            chk($sformatf("n2_y1_s%0d", s), y1_s[2], s == 4);
            chk($sformatf("n2_y2_s%0d", s), y2_s[2], 1'b0);
        end

        // Reset in the middle of the y2 window restarts the counter.
        rstn = 1'b1; step(); rstn = 1'b0;
        set_in(6'b001010);
        for (int s = 1; s <= 6; s++) step();
        chk("mid_pre_y2", y2_s[1], 1'b0);
        rstn = 1'b1; step();
        chk("mid_rst_y1", y1_s[1], 1'b0);
        chk("mid_rst_y2", y2_s[1], 1'b0);
        rstn = 1'b0;
        for (int s = 1; s <= 12; s++) begin
            step();
            chk($sformatf("mid_y2_s%0d", s), y2_s[1], (s >= 2) && !(s >= 5 && s <= 8));
        end

        // Random inputs with occasional resets; long runs exercise saturation.
        for (int i = 0; i < 400; i++) begin
            set_in(6'($urandom));
            rstn = ($urandom_range(0, 59) == 0);
            step();
        end
        rstn = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/injection_module_core.md
Name: injection_module_core

Overview:
- Small registered logic cone with a built-in, parameter-controlled stuck-at fault injector, used to validate fault-injection and detection flows.
- Six single-bit inputs feed a two-stage pipeline: three internal nodes, then two outputs y1/y2.
- A free-running cycle counter opens a programmable fault window. During the window, one selected node is forced to a fixed value.
- Sits standalone as a leaf block under a fault-injection test harness.

Parameters:
- FAULT_EN, 0: 1 enables the injector; 0 means no node is ever forced.
- FAULT_NODE, 0: node to force. 0=n1, 1=n2, 2=n3, 3=y1, 4=y2. Values 5–7 are treated as no target.
- FAULT_VAL, 0: stuck-at value applied to the selected node (0 or 1).
- FAULT_START, 4: counter value at which the fault window opens (inclusive).
- FAULT_LEN, 4: window length in cycles. 0 means the window never opens.
- CNT_W, 16: width of the cycle counter.

Ports:
- clk  input  1  rising-edge clock; all state changes on this edge.
- rstn  input  1  synchronous, active-high reset (1 = reset), sampled on rising clk.
- a  input  1  data input.
- b  input  1  data input.
- c  input  1  data input.
- d  input  1  data input.
- e  input  1  data input.
- f  input  1  data input.
- y1  output  1  registered result: n1 | n2.
- y2  output  1  registered result: n2 & n3.

Behaviour:
- Reset: when rstn=1 at a rising edge, the following clear to 0: n1, n2, n3, y1, y2, the counter cnt, and the window flag. Reset has priority over all other updates, including a window in progress. Outputs read 0 the cycle after reset is sampled.
- Stage 1 (registered), each edge out of reset:
  - n1 <= a & b
  - n2 <= c ^ d
  - n3 <= e | f
- Stage 2 (registered), using current stage-1 values:
  - y1 <= n1 | n2
  - y2 <= n2 & n3
- Latency: exactly 2 clk edges from input to output. The block is fully pipelined and accepts a new input set every cycle. There is no handshake.
- Counter: cnt increments by 1 each edge out of reset and saturates at all-ones; it does not wrap.
- Window flag win: win = FAULT_EN && FAULT_LEN!=0 && cnt >= FAULT_START && cnt < FAULT_START+FAULT_LEN.
  - Evaluated combinationally from the current cnt.
  - Computed at CNT_W+1 bits so the end bound cannot overflow.
- Injection: when win=1, the register selected by FAULT_NODE loads FAULT_VAL instead of its normal next value. The forced value propagates normally into downstream stages.
  - Non-selected nodes are unaffected.
  - Once win falls, the node resumes normal computation on the next edge.
- Boundary conditions:
  - FAULT_START=0: the window opens on the first edge after reset release.
  - Saturated cnt with an end bound beyond all-ones: the window stays open indefinitely.
  - FAULT_EN=0, or FAULT_NODE >= 5: output is identical to the fault-free design for every cycle.
  - Reset during the window: the window closes and cnt restarts from 0, so the window reoccurs after release.
- No X propagation out of reset: every register has a defined reset value.

Test Plan:
- Reset: hold rstn=1 for 3 edges with all inputs=1 -> y1=0, y2=0. Release, keep a..f=1 -> after 2 edges, n1=1, n2=0, n3=1, so y1=1, y2=0.
- Latency/truth: from reset release, apply a=1,b=1,c=1,d=0,e=0,f=1 from edge 0 -> y1=1, y2=1 from edge 2. Change to c=0 -> y1=1, y2=0 two edges later.
- All-zero: a..f=0 -> y1=0, y2=0. Then set c=1,e=1 -> y1=1, y2=1 two edges later.
- Injection on y2: FAULT_EN=1, FAULT_NODE=4, FAULT_VAL=0, START=4, LEN=4, inputs held at c=1,e=1 -> y2=1 except during window edges 4–7 (cnt 4..7), where y2=0. y1 stays 1 throughout.
- Injection on n2 propagation: FAULT_NODE=1, FAULT_VAL=1, all inputs 0, START=2, LEN=1 -> y1 pulses 1 for exactly one cycle, 1 edge after n2 is forced. y2 stays 0.
- Mid-window reset: same setup as the y2 injection, with rstn=1 for one edge at cnt=5 -> outputs 0. After release, cnt restarts from 0 and the window reopens at cnt 4–7.
